// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types for the m_serializer transmitter
package serializer_pkg;
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
endpackage

// File: rtl/m_counter.sv
// m_counter: up/down counter with sync clear, parallel load and count enable
// ports: clk, clr (to zero), ld/init (load value), en (count), up (1=inc, 0=dec), q
module m_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] init,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (ld) q <= init;
    else if (en) q <= up ? q + 1'b1 : q - 1'b1;
endmodule

// File: rtl/m_piso_shift_register.sv
// m_piso_shift_register: parallel-load shift register emitting its leading end
// ports: clk, clr (sync clear), load/d/left (capture word and direction), shift, q (serial bit)
module m_piso_shift_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic         left,
  input  logic [W-1:0] d,
  output logic         q
);
  logic [W-1:0] sh;
  logic         dir;
  always_ff @(posedge clk)
    if (clr) begin
      sh  <= '0;
      dir <= 1'b0;
    end else if (load) begin
      sh  <= d;
      dir <= left;
    end else if (shift) sh <= dir ? sh << 1 : sh >> 1;
  assign q = dir ? sh[W-1] : sh[0];
endmodule

// File: rtl/m_serializer.sv
// m_serializer: valid/ready parallel-in, serial-out transmitter, one bit per DIV clocks
// ports: clk, clr_n (sync active-low), data/valid/ready/left (word handshake),
//        s_out/s_en (serial bit and end-of-bit strobe), busy, done (word sent pulse)
module m_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  input  logic             left,
  output logic             s_out,
  output logic             s_en,
  output logic             busy,
  output logic             done
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  state_t        state, next;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic          hs, last, bit_q;
  assign hs   = valid & ready;
  assign last = s_en && cnt == CW'(1);
  m_counter #(.W(DW)) u_div (
    .clk(clk), .clr(~clr_n | hs | s_en), .ld(1'b0), .init('0),
    .en(busy), .up(1'b1), .q(div)
  );
  m_counter #(.W(CW)) u_cnt (
    .clk(clk), .clr(~clr_n), .ld(hs), .init(CW'(WIDTH)),
    .en(s_en), .up(1'b0), .q(cnt)
  );
  m_piso_shift_register #(.W(WIDTH)) u_sh (
    .clk(clk), .clr(~clr_n), .load(hs), .shift(s_en), .left(left),
    .d(data), .q(bit_q)
  );
  // done marks the first idle cycle after a completed word; reset suppresses it
  always_ff @(posedge clk)
    if (!clr_n) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= next;
      done  <= state == S_SHIFT && next == S_IDLE;
    end
  always_comb
    next = state == S_IDLE ? (valid ? S_SHIFT : S_IDLE) : (last ? S_IDLE : S_SHIFT);
  always_comb begin
    ready = state == S_IDLE;
    busy  = state == S_SHIFT;
    s_en  = busy && div == DW'(DIV - 1);
    s_out = busy & bit_q;
  end
endmodule
